// File: rtl/pp_pipeline_accel_mac_pipe.sv
// Pipelined multiply-accumulate with per-operand signedness, saturating accumulator,
// round-half-up shift and output saturation behind a valid/ready stream with global stall.
module pp_pipeline_accel_mac_pipe #(
    parameter int DIN0_WIDTH = 9,
    parameter int DIN1_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int DOUT_WIDTH = 17,
    parameter int NUM_STAGE  = 3,
    parameter int SHIFT      = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DIN0_WIDTH-1:0]        din0,
    input  logic [DIN1_WIDTH-1:0]        din1,
    input  logic                         din0_signed,
    input  logic                         din1_signed,
    input  logic                         acc_en,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         out_sat
);

    localparam int PW  = DIN0_WIDTH + DIN1_WIDTH + 2;
    localparam int AW  = ACC_WIDTH;
    localparam int DW  = DOUT_WIDTH;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [AW:0]   RND     = (AW+1)'((SHIFT > 0) ? (64'd1 << RSH) : 64'd0);
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [DW-1:0] DOUT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] DOUT_MIN = {1'b1, {(DW-1){1'b0}}};

    // Operands carry one extra bit so unsigned values stay positive in signed arithmetic.
    function automatic logic signed [PW-1:0] mul(input logic signed [DIN0_WIDTH:0] a,
                                                  input logic signed [DIN1_WIDTH:0] b);
        logic signed [PW-1:0] aw;
        logic signed [PW-1:0] bw;
        aw = PW'(a);
        bw = PW'(b);
        return aw * bw;
    endfunction

    logic ce;
    logic accept;
    logic in_term;
    logic signed [DIN0_WIDTH:0] a_in;
    logic signed [DIN1_WIDTH:0] b_in;

    assign ce       = !out_valid || out_ready;
    assign in_ready = ce && !reset;
    assign accept   = in_valid && in_ready;
    assign in_term  = !acc_en || in_last;
    assign a_in     = {din0_signed & din0[DIN0_WIDTH-1], din0};
    assign b_in     = {din1_signed & din1[DIN1_WIDTH-1], din1};

    logic fin_v;
    logic fin_term;
    logic signed [PW-1:0] fin_p;

    generate
        if (NUM_STAGE == 1) begin : g_comb
            assign fin_v    = accept;
            assign fin_term = in_term;
            assign fin_p    = mul(a_in, b_in);
        end else begin : g_pipe
            logic v1;
            logic t1;
            logic signed [DIN0_WIDTH:0] a1;
            logic signed [DIN1_WIDTH:0] b1;
            logic signed [PW-1:0] p1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v1 <= 1'b0;
                    t1 <= 1'b0;
                    a1 <= '0;
                    b1 <= '0;
                end else if (ce) begin
                    v1 <= accept;
                    t1 <= in_term;
                    a1 <= a_in;
                    b1 <= b_in;
                end
            end

            assign p1 = mul(a1, b1);

            if (NUM_STAGE == 2) begin : g_two
                assign fin_v    = v1;
                assign fin_term = t1;
                assign fin_p    = p1;
            end else begin : g_deep
                logic [NUM_STAGE-3:0] vv;
                logic [NUM_STAGE-3:0] tt;
                logic signed [PW-1:0] pp [NUM_STAGE-2];

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        vv <= '0;
                        tt <= '0;
                        for (int i = 0; i < NUM_STAGE - 2; i++) pp[i] <= '0;
                    end else if (ce) begin
                        vv[0] <= v1;
                        tt[0] <= t1;
                        pp[0] <= p1;
                        for (int i = 1; i < NUM_STAGE - 2; i++) begin
                            vv[i] <= vv[i-1];
                            tt[i] <= tt[i-1];
                            pp[i] <= pp[i-1];
                        end
                    end
                end

                assign fin_v    = vv[NUM_STAGE-3];
                assign fin_term = tt[NUM_STAGE-3];
                assign fin_p    = pp[NUM_STAGE-3];
            end
        end
    endgenerate

    logic signed [AW-1:0] acc;
    logic                 ovf;
    logic signed [AW:0]   p_ext;
    logic signed [AW:0]   sum;
    logic signed [AW:0]   rnd;
    logic signed [AW:0]   shr;
    logic signed [AW-1:0] s;
    logic [AW-DW+1:0]     hi;
    logic                 acc_clip;
    logic                 dout_clip;
    logic signed [DW-1:0] r_sat;

    always_comb begin
        p_ext    = (AW+1)'(fin_p);
        sum      = {acc[AW-1], acc} + p_ext;
        acc_clip = sum[AW] != sum[AW-1];
        s        = acc_clip ? (sum[AW] ? ACC_MIN : ACC_MAX) : sum[AW-1:0];
        // One guard bit keeps the rounding add from wrapping at full-scale positive.
        rnd       = {s[AW-1], s} + RND;
        shr       = rnd >>> SHIFT;
        hi        = shr[AW:DW-1];
        dout_clip = !((&hi) || (~|hi));
        r_sat     = dout_clip ? (shr[AW] ? DOUT_MIN : DOUT_MAX) : shr[DW-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            ovf       <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            if (fin_v && fin_term) begin
                dout      <= r_sat;
                out_sat   <= ovf | acc_clip | dout_clip;
                out_valid <= 1'b1;
                acc       <= '0;
                ovf       <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                if (fin_v) begin
                    acc <= s;
                    ovf <= ovf | acc_clip;
                end
            end
        end
    end

endmodule

// File: tb/tb_pp_pipeline_accel_mac_pipe.sv
// Directed bench for pp_pipeline_accel_mac_pipe: default instance plus a SHIFT=4 instance,
// results checked against a queue of expected {out_sat, dout} values.
module tb_pp_pipeline_accel_mac_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv0, iv1;
    logic        rdy0, rdy1;
    logic [8:0]  din0;
    logic [7:0]  din1;
    logic        din0_signed, din1_signed, acc_en, in_last;
    logic        out_ready;
    logic        ov0, ov1;
    logic        sat0, sat1;
    logic signed [16:0] dout0, dout1;

    int checks = 0;
    int errors = 0;
    logic [17:0] q0[$];
    logic [17:0] q1[$];
    logic [17:0] exp_v;
    logic [17:0] prev_val;
    logic        prev_stall = 1'b0;

    always #5 clk = ~clk;

    pp_pipeline_accel_mac_pipe u0 (
        .clk(clk), .reset(reset), .in_valid(iv0), .in_ready(rdy0),
        .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
        .acc_en(acc_en), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
        .dout(dout0), .out_sat(sat0)
    );

    pp_pipeline_accel_mac_pipe #(.SHIFT(4)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(rdy1),
        .din0(din0), .din1(din1), .din0_signed(din0_signed), .din1_signed(din1_signed),
        .acc_en(acc_en), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
        .dout(dout1), .out_sat(sat1)
    );

    function automatic logic [17:0] model(input logic [8:0] a, input logic [7:0] b,
                                          input logic sa, input logic sb, input int sh);
        longint va, vb, r;
        logic   st;
        va = longint'(a);
        vb = longint'(b);
        if (sa && a[8]) va = va - 512;
        if (sb && b[7]) vb = vb - 256;
        r = va * vb;
        if (sh > 0) r = (r + (longint'(1) << (sh - 1))) >>> sh;
        st = 1'b0;
        if (r > 65535) begin
            r  = 65535;
            st = 1'b1;
        end else if (r < -65536) begin
            r  = -65536;
            st = 1'b1;
        end
        return {st, r[16:0]};
    endfunction

    task automatic send(input int sel, input logic [8:0] a, input logic [7:0] b,
                        input logic sa, input logic sb, input logic en, input logic last);
        int t;
        din0 = a; din1 = b; din0_signed = sa; din1_signed = sb; acc_en = en; in_last = last;
        if (sel == 0) iv0 = 1'b1; else iv1 = 1'b1;
        #1;
        t = 0;
        while (((sel == 0) ? rdy0 : rdy1) == 1'b0 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        checks++;
        assert (t < 200) else begin
            errors++;
            $error("FAIL send_timeout observed %0d cycles required <200", t);
        end
        @(posedge clk);
        @(negedge clk);
        iv0 = 1'b0;
        iv1 = 1'b0;
    endtask

    // Output monitor and stall checks, sampled mid-low-phase after drivers settle.
    always begin
        @(negedge clk); #2;
        if (!reset) begin
            if (ov0 && out_ready) begin
                checks++;
                assert (q0.size() != 0) else begin
                    errors++;
                    $error("FAIL u0_unexpected observed dout %0d required none", dout0);
                end
                if (q0.size() != 0) begin
                    exp_v = q0.pop_front();
                    checks++;
                    assert ({sat0, dout0} === exp_v) else begin
                        errors++;
                        $error("FAIL u0_result observed sat %0b dout %0d required sat %0b dout %0d",
                               sat0, dout0, exp_v[17], $signed(exp_v[16:0]));
                    end
                end
            end
            if (ov1 && out_ready) begin
                checks++;
                assert (q1.size() != 0) else begin
                    errors++;
                    $error("FAIL u1_unexpected observed dout %0d required none", dout1);
                end
                if (q1.size() != 0) begin
                    exp_v = q1.pop_front();
                    checks++;
                    assert ({sat1, dout1} === exp_v) else begin
                        errors++;
                        $error("FAIL u1_result observed sat %0b dout %0d required sat %0b dout %0d",
                               sat1, dout1, exp_v[17], $signed(exp_v[16:0]));
                    end
                end
            end
            if (ov0 && !out_ready) begin
                checks++;
                assert (rdy0 === 1'b0) else begin
                    errors++;
                    $error("FAIL stall_in_ready observed %0b required 0", rdy0);
                end
                if (prev_stall) begin
                    checks++;
                    assert ({sat0, dout0} === prev_val) else begin
                        errors++;
                        $error("FAIL stall_hold observed %0h required %0h", {sat0, dout0}, prev_val);
                    end
                end
            end
            prev_stall = ov0 && !out_ready;
            prev_val   = {sat0, dout0};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset = 1'b1; iv0 = 1'b0; iv1 = 1'b0; out_ready = 1'b1;
        din0 = '0; din1 = '0; din0_signed = 1'b0; din1_signed = 1'b0;
        acc_en = 1'b0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        assert ({ov0, sat0, dout0, rdy0} === 20'h0) else begin
            errors++;
            $error("FAIL reset_state observed ov %0b sat %0b dout %0d rdy %0b required 0",
                   ov0, sat0, dout0, rdy0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        assert (rdy0 === 1'b1) else begin
            errors++;
            $error("FAIL ready_after_reset observed %0b required 1", rdy0);
        end
        @(negedge clk);

        // Signed single beat and latency.
        q0.push_back({1'b0, 17'd32768});
        send(0, 9'h100, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0);
        lat = 1;
        while (!ov0 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        assert (lat == 3) else begin
            errors++;
            $error("FAIL latency observed %0d required 3", lat);
        end
        @(negedge clk);

        // Unsigned and mixed signedness.
        q0.push_back({1'b1, 17'd65535});
        send(0, 9'h1FF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        q0.push_back({1'b0, -17'sd255});
        send(0, 9'h1FF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Four-beat accumulation then a single beat.
        q0.push_back({1'b0, 17'd40000});
        for (int i = 0; i < 4; i++) send(0, 9'd100, 8'd100, 1'b1, 1'b1, 1'b1, (i == 3));
        q0.push_back({1'b0, 17'd6});
        send(0, 9'd2, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        checks++;
        assert (q0.size() == 0) else begin
            errors++;
            $error("FAIL directed_drain observed %0d pending required 0", q0.size());
        end

        // Random stream with a 5-cycle downstream stall.
        fork
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
        join_none
        for (int i = 0; i < 20; i++) begin
            logic [8:0] a;
            logic [7:0] b;
            logic       sa, sb;
            a  = 9'($urandom_range(0, 511));
            b  = 8'($urandom_range(0, 255));
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            q0.push_back(model(a, b, sa, sb, 0));
            send(0, a, b, sa, sb, 1'b0, 1'b0);
        end
        repeat (8) @(negedge clk);
        checks++;
        assert (q0.size() == 0) else begin
            errors++;
            $error("FAIL stream_drain observed %0d pending required 0", q0.size());
        end

        // Rounding on the SHIFT=4 instance.
        q1.push_back({1'b0, 17'd2});
        send(1, 9'd3, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        q1.push_back({1'b0, -17'sd1});
        send(1, 9'h1FD, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        q1.push_back({1'b0, 17'd1});
        send(1, 9'd1, 8'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        checks++;
        assert (q1.size() == 0) else begin
            errors++;
            $error("FAIL round_drain observed %0d pending required 0", q1.size());
        end

        // Reset mid-group discards the partial sum.
        send(0, 9'd50, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0);
        send(0, 9'd50, 8'd50, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #2;
        checks++;
        assert ({ov0, sat0, dout0, rdy0} === 20'h0) else begin
            errors++;
            $error("FAIL mid_reset observed ov %0b sat %0b dout %0d rdy %0b required 0",
                   ov0, sat0, dout0, rdy0);
        end
        @(negedge clk);
        reset = 1'b0;
        q0.push_back({1'b0, 17'd1});
        send(0, 9'd1, 8'd1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        checks++;
        assert (q0.size() == 0 && q1.size() == 0) else begin
            errors++;
            $error("FAIL final_drain observed %0d/%0d pending required 0", q0.size(), q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_pipeline_accel_mac_pipe.md
# pp_pipeline_accel_mac_pipe

Parametrised, pipelined multiply-accumulate unit for the pp_pipeline_accel datapath. It succeeds the fixed-width combinational signed multipliers. Each operand's signedness is selected per beat. It can sum a group of products into a saturating accumulator, then rounds, shifts and saturates to the output width. A valid/ready stream interface and a global pipeline stall let it sit between the pre-processing stream stages.

## Interface
- DIN0_WIDTH, 9: width of din0.
- DIN1_WIDTH, 8: width of din1.
- ACC_WIDTH, 24: signed accumulator width. Must be ≥ DIN0_WIDTH+DIN1_WIDTH+1.
- DOUT_WIDTH, 17: signed output width. Must be ≤ ACC_WIDTH.
- NUM_STAGE, 3: input-accept to output-valid latency in cycles. Must be ≥ 1.
- SHIFT, 0: arithmetic right shift applied before output. Range 0..ACC_WIDTH-1.
- clk  in  1  clock; all registers update on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- din0  in  DIN0_WIDTH  operand A.
- din1  in  DIN1_WIDTH  operand B.
- din0_signed  in  1  1: din0 is two's complement; 0: din0 is unsigned.
- din1_signed  in  1  same selection for din1.
- acc_en  in  1  1: beat joins the running accumulation.
- in_last  in  1  closes the accumulation group (meaningful only when acc_en=1).
- out_valid  out  1  dout/out_sat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- dout  out  DOUT_WIDTH  signed result.
- out_sat  out  1  result or its accumulation saturated.

## Operation
- Extension: each operand is extended by 1 bit, zero- or sign-extended per its signed flag. The product p is exact, computed as a signed (DIN0_WIDTH+DIN1_WIDTH+2)-bit value.
- Pipeline: stages 1..NUM_STAGE-1 register operands and partial products. With NUM_STAGE=1 the product is combinational into the final stage. The final stage holds the accumulator acc (ACC_WIDTH, signed), the sticky flag ovf, and the output register.
- Terminal beat: a beat with acc_en=0, or with acc_en=1 and in_last=1.
- Non-terminal beat:
  - acc <= sat_ACC(acc + p).
  - ovf |= saturation occurred.
  - No output is produced.
- Terminal beat:
  - s = sat_ACC(acc + p).
  - r = (s + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, i.e. round-half-up. The rounding add is computed at ACC_WIDTH+1 bits, so it cannot wrap.
  - dout <= sat_DOUT(r).
  - out_sat <= ovf | ACC saturation | DOUT saturation.
  - acc <= 0, ovf <= 0, out_valid <= 1.
- A beat with acc_en=0 arriving mid-group terminates that group. Its product is included in the emitted sum.
- Saturation clamps to [-2^(W-1), 2^(W-1)-1].

## Timing
- Stall: ce = !out_valid || out_ready.
  - in_ready = ce, and in_ready = 0 while reset is asserted.
  - When ce=0, every stage, acc, ovf, dout and out_valid hold.
  - Pipeline bubbles still advance when ce=1.
- Latency: a terminal beat accepted at edge k gives out_valid=1 after edge k+NUM_STAGE-1, i.e. visible in cycle k+NUM_STAGE.
- Throughput: 1 beat/cycle when out_ready is held high.
- out_valid drops on the edge that completes the handshake, unless a new result loads on that same edge.
- Beats are never dropped, duplicated or reordered. dout and out_sat stay stable while out_valid && !out_ready.
- Reset, asynchronous on assertion: all stage valids 0, acc 0, ovf 0, dout 0, out_sat 0, out_valid 0.
  - After reset deasserts, in_ready=1.
  - Reset mid-group discards the partial sum; the next beat starts a fresh group.
- Simultaneous output handshake and input accept are legal and lose no data.

## Test plan
- Signed single beat (defaults): din0=0x100 (-256), din1=0x80 (-128), both signed, acc_en=0 -> dout=32768, out_sat=0. out_valid is seen 3 cycles after accept.
- Unsigned/mixed:
  - 511×255, both unsigned -> dout=65535, out_sat=1.
  - din0=0x1FF signed (-1), din1=0xFF unsigned (255) -> dout=-255, out_sat=0.
- Accumulate: four beats of 100×100, acc_en=1, in_last on the 4th -> exactly one out_valid pulse, dout=40000, 3 cycles after the 4th accept. A following single beat 2×3 with acc_en=0 -> dout=6.
- Backpressure: a stream of 20 beats with out_ready low for 5 cycles mid-stream -> in_ready=0 while stalled. All 20 results appear in order with no loss or duplication, and dout is held stable while stalled.
- Rounding (SHIFT=4 instance): 3×8 (=24) -> dout=2. -3×8 (=-24) -> dout=-1. 1×8 -> dout=1 (half rounds up).
- Reset mid-group: accept two acc_en=1 beats 50×50, assert reset for 1 cycle -> all outputs 0. Then a single beat 1×1 with in_last=1 -> dout=1.
